// File: rtl/aes_pkg.sv
// Shared AES constants and byte/word helpers for the key schedule and round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    KeyLen128  = 2'd0,
    KeyLen192  = 2'd1,
    KeyLen256  = 2'd2,
    KeyLenRsvd = 2'd3
  } key_len_e;

  typedef enum logic [0:0] {
    StIdle,
    StExpand
  } ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box, byte 0x00 in the top eight bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = 11'd2040 - {x, 3'b000};
    return SBOX[pos +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len_e'(key_len))
      KeyLen128: return 4'd4;
      KeyLen192: return 4'd6;
      KeyLen256: return 4'd8;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [3:0] nk);
    return nk + 4'd6;
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Control and round-key read bus of the AES key-schedule engine.
interface aes_key_sched_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [3:0]   num_rounds;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         rk_valid;

  modport master (
    output start, key_len, key, rk_idx,
    input  busy, done, err, keys_valid, num_rounds, rk_data, rk_valid
  );

  modport slave (
    input  start, key_len, key, rk_idx,
    output busy, done, err, keys_valid, num_rounds, rk_data, rk_valid
  );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign data_o[8*g +: 8] = sbox(data_i[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle, with an
// indexed round-key read port over the stored schedule.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK = 8,
  parameter int unsigned RD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  aes_key_sched_if.slave bus
);

  localparam int unsigned Depth = 4 * (MAX_NK + 7);

  logic [31:0] w [Depth];

  ks_state_e   state_q;
  logic [5:0]  i_q;
  logic [2:0]  m_q;
  logic [7:0]  rcon_q;
  logic [3:0]  nk_q, nr_q;
  logic        busy_q, done_q, err_q, keys_valid_q;
  logic [3:0]  num_rounds_q;

  logic [3:0]  req_nk;
  logic        start_ok, start_acc, expand_we;
  logic [31:0] prev_word, sub_in, sub_out, temp, new_word;

  assign req_nk    = nk_of(bus.key_len);
  assign start_ok  = key_len_e'(bus.key_len) != KeyLenRsvd && 32'(req_nk) <= MAX_NK;
  assign start_acc = !rst && state_q == StIdle && bus.start && start_ok;
  assign expand_we = !rst && state_q == StExpand;

  assign prev_word = w[i_q - 6'd1];
  assign sub_in    = (m_q == 3'd0) ? rot_word(prev_word) : prev_word;

  aes_subword u_subword (
    .data_i (sub_in),
    .data_o (sub_out)
  );

  always_comb begin
    temp = prev_word;
    if (m_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && m_q == 3'd4) begin
      temp = sub_out;
    end
    new_word = w[i_q - {2'b00, nk_q}] ^ temp;
  end

  // Schedule storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      for (int k = 0; k < int'(MAX_NK); k++) begin
        if (k < int'(req_nk)) w[6'(k)] <= bus.key[255 - 32*k -: 32];
      end
    end else if (expand_we) begin
      w[i_q] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      i_q          <= 6'd0;
      m_q          <= 3'd0;
      rcon_q       <= RCON_INIT;
      nk_q         <= 4'd0;
      nr_q         <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      keys_valid_q <= 1'b0;
      num_rounds_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (start_ok) begin
              state_q      <= StExpand;
              busy_q       <= 1'b1;
              i_q          <= {2'b00, req_nk};
              m_q          <= 3'd0;
              rcon_q       <= RCON_INIT;
              nk_q         <= req_nk;
              nr_q         <= nr_of(req_nk);
              keys_valid_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StExpand: begin
          i_q <= i_q + 6'd1;
          m_q <= ({1'b0, m_q} == nk_q - 4'd1) ? 3'd0 : m_q + 3'd1;
          if (m_q == 3'd0) rcon_q <= xtime(rcon_q);
          // Last word of the schedule is w[4*Nr+3].
          if (i_q == {nr_q, 2'b11}) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
            num_rounds_q <= nr_q;
            done_q       <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic         rd_valid_c;
  logic [127:0] rd_data_c;

  always_comb begin
    rd_valid_c = keys_valid_q && bus.rk_idx <= num_rounds_q;
    rd_data_c  = '0;
    if (rd_valid_c) begin
      for (int k = 0; k < 4; k++) begin
        rd_data_c[127 - 32*k -: 32] = w[{bus.rk_idx, 2'(k)}];
      end
    end
  end

  if (RD_LAT == 0) begin : g_rd_comb
    assign bus.rk_valid = rd_valid_c;
    assign bus.rk_data  = rd_data_c;
  end else begin : g_rd_reg
    logic         rk_valid_q;
    logic [127:0] rk_data_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rk_valid_q <= 1'b0;
        rk_data_q  <= '0;
      end else begin
        rk_valid_q <= rd_valid_c;
        rk_data_q  <= rd_data_c;
      end
    end
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_data  = rk_data_q;
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.num_rounds = num_rounds_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using the FIPS-197 key-expansion vectors.
module tb_aes_key_sched;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  aes_key_sched_if bus ();
  aes_key_sched_if bus4 ();

  aes_key_sched #(.MAX_NK(8), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  aes_key_sched #(.MAX_NK(4), .RD_LAT(0)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns cycles from the start-sampling edge to done.
  task automatic run_key(input logic [1:0] kl, input logic [255:0] k, output int cyc);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.key     = k;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("kv_cleared_on_start", bus.keys_valid, 0);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic rd(input logic [3:0] idx);
    bus.rk_idx = idx;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;   bus.key_len = 2'd0;  bus.key = '0;  bus.rk_idx = 4'd0;
    bus4.start = 1'b0;  bus4.key_len = 2'd0; bus4.key = '0; bus4.rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_keys_valid", bus.keys_valid, 0);
    check("rst_num_rounds", bus.num_rounds, 0);
    check("rst_rk_valid", bus.rk_valid, 0);
    check("rst_rk_data", bus.rk_data, 0);

    // AES-128
    run_key(2'd0, K128, n);
    check("aes128_cycles", n, 40);
    check("aes128_nr", bus.num_rounds, 10);
    check("aes128_kv", bus.keys_valid, 1);
    rd(4'd1);
    check("aes128_rk1", bus.rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_rk1_valid", bus.rk_valid, 1);
    rd(4'd10);
    check("aes128_rk10", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd0);
    check("aes128_rk0", bus.rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(4'd11);
    check("aes128_rk11_valid", bus.rk_valid, 0);
    check("aes128_rk11_data", bus.rk_data, 0);

    // Reserved key length is rejected; prior schedule retained.
    bus.start = 1'b1;
    bus.key_len = 2'd3;
    bus.key = K256;
    @(negedge clk);
    bus.start = 1'b0;
    check("rsvd_err", bus.err, 1);
    check("rsvd_busy", bus.busy, 0);
    @(negedge clk);
    check("rsvd_err_pulse", bus.err, 0);
    check("rsvd_kv_kept", bus.keys_valid, 1);
    rd(4'd10);
    check("rsvd_rk10_kept", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192
    run_key(2'd1, K192, n);
    check("aes192_cycles", n, 46);
    check("aes192_nr", bus.num_rounds, 12);
    rd(4'd1);
    check("aes192_rk1", bus.rk_data, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(4'd12);
    check("aes192_rk12", bus.rk_data, 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd13);
    check("aes192_rk13_valid", bus.rk_valid, 0);

    // AES-256
    run_key(2'd2, K256, n);
    check("aes256_cycles", n, 52);
    check("aes256_nr", bus.num_rounds, 14);
    rd(4'd0);
    check("aes256_rk0", bus.rk_data, 128'h603deb1015ca71be2b73aef0857d7781);
    rd(4'd2);
    check("aes256_rk2", bus.rk_data, 128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(4'd3);
    check("aes256_rk3", bus.rk_data, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    rd(4'd14);
    check("aes256_rk14", bus.rk_data, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(4'd15);
    check("aes256_rk15_valid", bus.rk_valid, 0);

    // start during EXPAND is ignored; reads while busy are invalid.
    bus.rk_idx  = 4'd1;
    bus.start   = 1'b1;
    bus.key_len = 2'd0;
    bus.key     = K128;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (n == 5) begin
        bus.start = 1'b1;
        bus.key_len = 2'd2;
        bus.key = K256;
      end
      if (n == 6) bus.start = 1'b0;
      if (n == 10) begin
        check("busy_read_invalid", bus.rk_valid, 0);
        check("busy_no_err", bus.err, 0);
      end
    end
    check("ignore_cycles", n, 40);
    check("ignore_nr", bus.num_rounds, 10);

    // Back-to-back start in the cycle after done.
    run_key(2'd0, K128, n);
    check("b2b_cycles", n, 40);
    rd(4'd10);
    check("b2b_rk10", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // rst 20 cycles into an AES-128 run.
    bus.start = 1'b1;
    bus.key_len = 2'd0;
    bus.key = K128;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_kv", bus.keys_valid, 0);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) n++;
      @(negedge clk);
    end
    check("midrst_no_done", n, 0);
    rd(4'd10);
    check("midrst_rk_invalid", bus.rk_valid, 0);
    run_key(2'd0, K128, n);
    check("restart_cycles", n, 40);
    rd(4'd10);
    check("restart_rk10", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // MAX_NK = 4 instance: AES-256 rejected, AES-128 served combinationally.
    bus4.start = 1'b1;
    bus4.key_len = 2'd2;
    bus4.key = K256;
    @(negedge clk);
    bus4.start = 1'b0;
    check("nk4_err", bus4.err, 1);
    check("nk4_busy", bus4.busy, 0);
    bus4.start = 1'b1;
    bus4.key_len = 2'd0;
    bus4.key = K128;
    @(negedge clk);
    bus4.start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus4.done) break;
    end
    check("nk4_cycles", n, 40);
    bus4.rk_idx = 4'd10;
    #1;
    check("nk4_rk10", bus4.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    bus4.rk_idx = 4'd11;
    #1;
    check("nk4_rk11_valid", bus4.rk_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
- Iterative, clocked AES key-expansion engine for AES-128, AES-192 and AES-256 (FIPS-197 §5.2).
- Produces one 32-bit schedule word per cycle, so it needs only one 4-byte S-box bank, not a full combinational unroll.
- Stores the expanded schedule internally and serves any round key through an indexed read port.
- Sits between key load and the encrypt/decrypt round datapath.

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words. Legal values are 4, 6 and 8. Sets storage depth to 4*(MAX_NK+7) words.
- RD_LAT, 1, read-port latency in cycles. Legal values are 0 (combinational) and 1 (registered).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request to begin an expansion; sampled only in IDLE.
- key_len  in  2  key length: 0 = AES-128, 1 = AES-192, 2 = AES-256. 3 is reserved.
- key  in  256  cipher key, left-aligned: w0 = key[255:224]. Unused low bits are ignored.
- busy  out  1  high while in EXPAND.
- done  out  1  one-cycle pulse when the schedule is complete.
- err  out  1  one-cycle pulse when start is rejected.
- keys_valid  out  1  level; high from done until the next accepted start or rst.
- num_rounds  out  4  Nr of the stored schedule (10, 12 or 14); 0 after reset.
- rk_idx  in  4  round-key index to read, 0..Nr.
- rk_data  out  128  round key rk_idx: rk_data[127:96] = w[4*rk_idx], through rk_data[31:0] = w[4*rk_idx+3].
- rk_valid  out  1  qualifies rk_data.

Behaviour:
- Reset values: busy, done, err, keys_valid, rk_valid = 0; num_rounds = 0; rk_data = 0; FSM = IDLE. Word storage is not reset.
- FSM has two states: IDLE and EXPAND.
- Start rejection (err pulses next cycle, no state change) when:
  - key_len = 3, or
  - the requested Nk exceeds MAX_NK.
- Accepted start in IDLE, same edge:
  - writes w[0..Nk-1] from key;
  - sets i = Nk, mod counter m = 0, rcon = 8'h01;
  - clears keys_valid;
  - latches Nk and Nr (Nr = Nk + 6) from key_len;
  - moves to EXPAND.
- start while busy is ignored. No err, and the running expansion is unaffected.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - If m == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon). xtime = left shift, XOR 8'h1b if bit 7 was set.
  - Else if Nk == 8 and m == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i increments; m wraps from Nk-1 to 0.
  - RotWord(a,b,c,d) = (b,c,d,a), with byte a in bits [31:24].
- EXPAND lasts exactly 4*(Nr+1) - Nk cycles: 40 for AES-128, 46 for AES-192, 52 for AES-256.
  - The edge that writes the last word (i = 4*Nr+3) returns the FSM to IDLE, sets keys_valid and num_rounds, and pulses done.
  - done therefore appears 40/46/52 cycles after the start-sampling edge.
- Read port:
  - rk_valid = keys_valid && rk_idx <= num_rounds, registered if RD_LAT = 1.
  - When rk_valid = 0, rk_data = 0.
  - Reads during EXPAND return rk_valid = 0.
  - Reading index 0 returns the original key words.
- rst mid-EXPAND: FSM returns to IDLE on that edge, keys_valid = 0, done is not pulsed. The partial schedule is discarded (unreadable).
- start coincident with rst: rst wins.
- Back-to-back: start may be accepted in the cycle after done. keys_valid drops on that edge.
- Width rules:
  - i is 6 bits (max 59).
  - All arithmetic is GF(2) XOR; there are no carries.
  - Storage index 4*rk_idx+k is at most 59.

Decomposition:
- Shared package aes_pkg holds:
  - S-box constant table (256x8);
  - key_len encodings and the Nk/Nr lookup;
  - RCON_INIT = 8'h01 and the xtime function;
  - RotWord function.
- One sub-module, aes_subword: four parallel S-box lookups on 32 bits, combinational, reused later by the round datapath.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done 40 cycles later; rk_idx 1 -> a0fafe1788542cb123a339392a6c7605; rk_idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx 11 -> rk_valid 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (left-aligned) -> done after 46 cycles, num_rounds 12; rk_idx 12 -> e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; rk_idx 14 -> fe4890d1e6188d0b046df344706c631e; rk_idx 0 -> 603deb1015ca71be2b73aef0857d7781.
- key_len = 3 -> err pulse, busy stays 0, prior keys_valid and contents retained. With MAX_NK = 4, key_len = 2 -> err.
- rst asserted 20 cycles into an AES-128 run -> busy 0 next cycle, no done, keys_valid 0. A restart then completes with the correct round-10 key.
- start re-asserted during EXPAND and in the cycle after done -> the first is ignored (schedule unchanged); the second is accepted (keys_valid falls, new done 40 cycles later).
